// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-ROM fetch controller with valid/ready hand-off to decode.
// Define SEQ_STEP_EN to add single-step debug (step_mode/step inputs, PAUSE state).
module fetch_sequencer #(
    parameter int                  ADDR_W   = 8,
    parameter int                  DATA_W   = 8,
    parameter int                  PROG_LEN = 65,
    parameter logic [DATA_W-1:0]   HALT_OP  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef SEQ_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] linenumber,
    input  logic [DATA_W-1:0] instr_in,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, FETCH, HOLD, HALT, PAUSE} state_e;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

    state_e            state_q;
    state_e            fetch_d;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;
    logic              err_q;

`ifdef SEQ_STEP_EN
    assign fetch_d = step_mode ? PAUSE : FETCH;
`else
    assign fetch_d = FETCH;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HALT: if (start) begin
                    pc_q    <= '0;
                    err_q   <= 1'b0;
                    state_q <= FETCH;
                end
                FETCH: begin
                    instr_q <= instr_in;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                // valid is always set in HOLD, so ready alone marks the handshake
                HOLD: if (instr_ready) begin
                    valid_q <= 1'b0;
                    if (instr_q == HALT_OP)
                        state_q <= HALT;
                    else if (branch_en && branch_addr <= LAST) begin
                        pc_q    <= branch_addr;
                        state_q <= fetch_d;
                    end else if (branch_en) begin
                        err_q   <= 1'b1;
                        state_q <= HALT;
                    end else if (pc_q == LAST)
                        state_q <= HALT;
                    else begin
                        pc_q    <= pc_q + 1'b1;
                        state_q <= fetch_d;
                    end
                end
`ifdef SEQ_STEP_EN
                PAUSE: if (step) state_q <= FETCH;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign linenumber  = pc_q;
    assign pc          = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign err         = err_q;
    assign halted      = state_q == HALT;
    assign busy        = state_q == FETCH || state_q == HOLD || state_q == PAUSE;
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the program ROM.
- Owns the program counter and drives `linenumber` to the ROM.
- Captures the 8-bit instruction the ROM returns combinationally and presents it to the decode/execute stage over a valid/ready handshake.
- Handles start, sequential advance, branch redirect, HALT opcode and end-of-program.

Parameters:
- ADDR_W, 8, width of program counter / linenumber
- DATA_W, 8, instruction width
- PROG_LEN, 65, number of valid ROM words; last valid address = PROG_LEN-1 (64)
- HALT_OP, 8'h00, opcode that stops sequencing once consumed

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle pulse; begins execution at address 0 from IDLE or HALT
- linenumber  output  ADDR_W  ROM address, equal to pc
- instr_in  input  DATA_W  ROM data for `linenumber`, combinational from ROM
- instr_out  output  DATA_W  captured instruction to decode
- instr_valid  output  1  instr_out holds an unconsumed instruction
- instr_ready  input  1  decode accepts instr_out this cycle
- branch_en  input  1  redirect request; sampled only on a handshake cycle
- branch_addr  input  ADDR_W  redirect target
- pc  output  ADDR_W  current program counter
- busy  output  1  state is FETCH or HOLD
- halted  output  1  state is HALT
- err  output  1  sticky; out-of-range branch occurred

Behaviour:
- Reset (rst=0, async):
  - State=IDLE.
  - pc=0, linenumber=0, instr_out=0, instr_valid=0, busy=0, halted=0, err=0.
- States: IDLE, FETCH, HOLD, HALT.
- IDLE:
  - Outputs quiescent.
  - start=1 -> pc<=0, err<=0, go FETCH.
- FETCH (one cycle):
  - linenumber=pc.
  - At the clock edge: instr_out<=instr_in, instr_valid<=1, go HOLD.
- HOLD:
  - instr_out and instr_valid are held stable until a handshake (instr_valid & instr_ready).
  - On a handshake, instr_valid<=0 and the next state is chosen in this priority:
    - 1. instr_out==HALT_OP -> HALT; pc unchanged.
    - 2. branch_en=1 and branch_addr<=PROG_LEN-1 -> pc<=branch_addr, go FETCH.
    - 3. branch_en=1 and branch_addr>PROG_LEN-1 -> err<=1, go HALT; pc unchanged.
    - 4. pc==PROG_LEN-1 -> HALT (end of program; no wrap to 0).
    - 5. Otherwise pc<=pc+1, go FETCH.
  - branch_en without a handshake is ignored.
- HALT:
  - halted=1, instr_valid=0; pc keeps its last value.
  - start=1 -> pc<=0, err<=0, go FETCH.
- start is ignored in FETCH and HOLD.
- Latency and throughput:
  - start to first instr_valid: 2 cycles (IDLE->FETCH, FETCH->HOLD).
  - With instr_ready held high: one instruction per 2 cycles.
- pc arithmetic is modulo 2^ADDR_W. The end-of-program check fires before the increment, so wrap is never reached.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, in-flight instruction discarded.

Optional Feature:
- SEQ_STEP_EN, single-step debug mode.
- Defined:
  - Adds inputs `step_mode` (1 bit) and `step` (1-bit pulse).
  - With step_mode=1, each handshake that would go to FETCH goes to an extra PAUSE state instead (busy=1, instr_valid=0, pc already updated).
  - PAUSE -> FETCH on step=1.
  - HALT and err paths are unchanged.
  - step_mode=0 behaves exactly as without the macro.
- Undefined: ports and PAUSE state absent.

Test Plan:
- Sequential run, PROG_LEN=6, ROM {8F,8B,85,9B,9D,97}, instr_ready=1, start pulse:
  - instr_out sequence 8F,8B,85,9B,9D,97.
  - instr_valid first high 2 cycles after start.
  - halted=1 after 6th handshake; pc=5.
- Backpressure: instr_ready=0 for 5 cycles while holding 8B -> instr_out stays 8B, instr_valid stays 1, pc stays 1. Then ready=1 -> pc=2.
- Branch: branch_en=1, branch_addr=0 on handshake of address 3 -> next linenumber=0, instr_out=8F. branch_en with ready=0 -> ignored.
- HALT opcode at address 2 (ROM[2]=00) -> after its handshake halted=1, pc=2, no further fetch. start -> fetch from address 0.
- Bad branch: branch_addr=70 with PROG_LEN=65 -> err=1, halted=1. Next start clears err.
- Async reset asserted in HOLD -> all outputs 0 the same cycle, state IDLE. start required to resume.
